// File: rtl/key_loader_pkg.sv
// Shared types and helpers for the key loader: FSM states, word/address sizing
// and the all-zeros key that leaves a locked netlist corrupted.
package key_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CHECK,
    COMMIT
  } state_e;

  localparam int MAX_KEY_WIDTH = 1024;
  localparam logic [MAX_KEY_WIDTH-1:0] ZERO_KEY = '0;

  function automatic int words_for(input int key_width, input int chunk_width);
    return key_width / chunk_width;
  endfunction

  // One extra code point so the optional parity word at index N is addressable.
  function automatic int addr_width(input int words);
    return (words < 1) ? 1 : $clog2(words + 1);
  endfunction

endpackage

// File: rtl/key_loader_wdog.sv
// Per-word watchdog: a loadable down-counter. kick_i reloads TIMEOUT,
// dec_i counts one idle cycle, expire_o flags the TIMEOUT-th consecutive idle cycle.
module key_loader_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic kick_i,
  input  logic dec_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (kick_i) begin
      count_d = LOAD;
    end else if (dec_i && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = dec_i && (count_q == W'(1));

endmodule

// File: rtl/key_loader.sv
// Fetches the secret key word by word into a shadow register, then commits it
// atomically to key_out. Optional column-parity word: define KEY_LOADER_PARITY_EN.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH   = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int TIMEOUT     = 255,
  localparam int N          = words_for(KEY_WIDTH, CHUNK_WIDTH),
  localparam int AW         = addr_width(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_addr,
  input  logic                   mem_ack,
  input  logic [CHUNK_WIDTH-1:0] mem_data,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic                   key_valid
);

`ifdef KEY_LOADER_PARITY_EN
  localparam int LAST_IDX = N;
`else
  localparam int LAST_IDX = N - 1;
`endif

  localparam logic [KEY_WIDTH-1:0] ZERO = KEY_WIDTH'(ZERO_KEY);

  state_e               state_q, state_d;
  logic [AW-1:0]        index_q, index_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 wd_kick, wd_dec, wd_expire;

`ifdef KEY_LOADER_PARITY_EN
  logic [CHUNK_WIDTH-1:0] parity_q, parity_d;

  function automatic logic [CHUNK_WIDTH-1:0] col_parity(input logic [KEY_WIDTH-1:0] k);
    logic [CHUNK_WIDTH-1:0] p;
    p = '0;
    for (int w = 0; w < N; w++) p ^= k[w*CHUNK_WIDTH +: CHUNK_WIDTH];
    return p;
  endfunction
`endif

  key_loader_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .kick_i   (wd_kick),
    .dec_i    (wd_dec),
    .expire_o (wd_expire)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d  = state_q;
    index_d  = index_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    valid_d  = valid_q;
    err_d    = err_q;
    done_d   = 1'b0;
    wd_kick  = 1'b0;
    wd_dec   = 1'b0;
`ifdef KEY_LOADER_PARITY_EN
    parity_d = parity_q;
`endif

    if (clear) begin
      // Zeroisation wins over everything, including a same-cycle commit.
      state_d  = IDLE;
      index_d  = '0;
      shadow_d = ZERO;
      key_d    = ZERO;
      valid_d  = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = REQ;
            index_d = '0;
            err_d   = 1'b0;
            wd_kick = 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            wd_kick = 1'b1;
            if (int'(index_q) < N) shadow_d[int'(index_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = mem_data;
`ifdef KEY_LOADER_PARITY_EN
            if (int'(index_q) == N) parity_d = mem_data;
`endif
            if (index_q == AW'(LAST_IDX)) begin
              index_d = '0;
`ifdef KEY_LOADER_PARITY_EN
              state_d = CHECK;
`else
              state_d = COMMIT;
`endif
            end else begin
              index_d = index_q + AW'(1);
            end
          end else begin
            wd_dec = 1'b1;
            if (wd_expire) begin
              // A stalled reload must not leave a stale key in place.
              state_d  = IDLE;
              index_d  = '0;
              shadow_d = ZERO;
              key_d    = ZERO;
              valid_d  = 1'b0;
              err_d    = 1'b1;
            end
          end
        end
`ifdef KEY_LOADER_PARITY_EN
        CHECK: begin
          if (col_parity(shadow_q) == parity_q) begin
            state_d = COMMIT;
          end else begin
            state_d  = IDLE;
            shadow_d = ZERO;
            err_d    = 1'b1;
          end
        end
`endif
        COMMIT: begin
          key_d   = shadow_q;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      // NOTE: the shadow holds key material, so it is reset like any other register.
      shadow_q <= ZERO;
      key_q    <= ZERO;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
      parity_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q  <= state_d;
      index_q  <= index_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef KEY_LOADER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = index_q;
  assign done      = done_q;
  assign err       = err_q;
  assign key_out   = key_q;
  assign key_valid = valid_q;

endmodule
